mix_sched: RTL and testbench
============================

MIX_SCHED -- requirements
Module: mix_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max BUSY cycles before engine abort (range 4..255).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  2  per-requester request valid (bit n = requester n).
REQ-005 SHALL have port req0_vec_i / req1_vec_i  input  128 each  requester input vectors.
REQ-006 SHALL have port req_ready_o  input-accept  output  2  one-hot grant/accept pulse.
REQ-007 SHALL have port resp_valid_o  output  1  result valid.
REQ-008 SHALL have port resp_id_o  output  1  requester that owns the result.
REQ-009 SHALL have port resp_data_o  output  128  engine result (mix_out packing).
REQ-010 SHALL have port resp_err_o  output  1  result aborted by timeout; data zero.
REQ-011 SHALL have port resp_ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port eng_vec_o  output  128  vector to mix engine vec_i.
REQ-013 SHALL have port eng_start_o  output  1  drives engine rst_i; one-cycle start pulse.
REQ-014 SHALL have port eng_done_i / eng_mix_i  input  1 / 128  engine done_out / mix_out.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, BUSY, RESP.
REQ-016 IDLE: if any req_valid_i, grant round-robin (priority to requester not granted last; requester 0 after reset), pulse req_ready_o for that bit, latch its vector into eng_vec_o, go LAUNCH next cycle.
REQ-017 Handshake: a request is accepted only in the cycle req_valid_i[n] & req_ready_o[n]; req_ready_o SHALL be zero outside IDLE.
REQ-018 LAUNCH: eng_start_o=1 for exactly one cycle, eng_vec_o stable; next state BUSY with cycle counter cleared.
REQ-019 BUSY: eng_vec_o held; eng_done_i=1 -> capture eng_mix_i into resp_data_o, resp_err_o=0, go RESP.
REQ-020 BUSY: counter reaching TIMEOUT without done -> resp_data_o=0, resp_err_o=1, go RESP; done in the same cycle as timeout wins (no error).
REQ-021 RESP: resp_valid_o=1 with data/id/err stable until resp_ready_i=1; that cycle -> IDLE, resp_valid_o drops next cycle.
REQ-022 Minimum latency accept->resp_valid_o = 3 + engine done latency cycles; back-to-back: new grant possible in the cycle after RESP handshake.
REQ-023 Requester deasserting valid before grant SHALL not be granted; both valid -> strict alternation.
REQ-024 eng_done_i outside BUSY SHALL be ignored.

Reset
REQ-025 rst_i=1 SHALL force IDLE, round-robin pointer to requester 1 last-granted, counter 0, all outputs 0 except eng_start_o=1 (engine held in reset).
REQ-026 Reset mid-operation SHALL drop the in-flight job with no response.

Configuration
REQ-027 Macro MIX_SCHED_CG_EN SHALL add output eng_cg_en_o (1): high in LAUNCH and BUSY only, for engine clock gating; without the macro the port does not exist and behaviour is otherwise identical.

Structure
REQ-028 Package mix_pkg SHALL hold WIDTH=8, DIM=4, VEC_W=128, the state enum and matrix_t typedef.
REQ-029 Round-robin grant SHALL be sub-module rr_arb2 (req[1:0], last pointer -> one-hot grant), combinational with pointer register in mix_sched.

Verification
REQ-030 Single req0 with vec 0 -> one req_ready_o=01 pulse, one eng_start_o pulse, resp_id_o=0, resp_data_o equals golden result for 0.
REQ-031 Both valid continuously, 4 jobs -> grant order 0,1,0,1; ids match; data matches golden per vector.
REQ-032 Engine model never asserts done, TIMEOUT=8 -> resp_err_o=1, resp_data_o=0 after 8 BUSY cycles.
REQ-033 resp_ready_i held low 20 cycles -> resp_valid_o/data stable, no new grant until accept.
REQ-034 rst_i asserted during BUSY -> next cycle IDLE, all outputs 0, eng_start_o=1, no response.
REQ-035 With MIX_SCHED_CG_EN, 50 idle cycles between jobs -> eng_cg_en_o=0 throughout idle, 1 only LAUNCH..BUSY.

Source files
------------

// File: rtl/mix_pkg.sv
// mix_pkg -- shared types and constants for the mix scheduler slice.
//   WIDTH / DIM / VEC_W : element width, matrix dimension and flat vector width
//   matrix_t            : DIM x DIM matrix of WIDTH-bit elements (packs to VEC_W)
//   state_e             : scheduler FSM states
package mix_pkg;

    localparam int WIDTH = 8;
    localparam int DIM   = 4;
    localparam int VEC_W = 128;

    typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester round-robin arbiter (purely combinational).
//   i_req   : request bits, bit n = requester n
//   i_last  : requester granted most recently
//   o_grant : one-hot grant (zero when nothing is requested)
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // Contention goes to the requester that was not served last; a lone request wins outright.
    always_comb begin
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            if (i_last) begin
                o_grant = 2'b01;
            end else begin
                o_grant = 2'b10;
            end
        end else begin
            o_grant = i_req;
        end
    end

endmodule

// File: rtl/mix_sched.sv
// mix_sched -- schedules jobs from two requesters onto a single mix engine.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_valid_i / req_ready_o : per-requester request and one-hot accept pulse (IDLE only)
//   req0_vec_i, req1_vec_i    : requester input vectors
//   eng_vec_o, eng_start_o    : engine input vector and start pulse (drives engine reset)
//   eng_done_i, eng_mix_i     : engine completion flag and result
//   resp_*                    : result handshake; resp_err_o marks a timed-out job (data zero)
// Optional build macro MIX_SCHED_CG_EN adds eng_cg_en_o, high in LAUNCH and BUSY only.
module mix_sched
    import mix_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    input  logic [VEC_W-1:0] req0_vec_i,
    input  logic [VEC_W-1:0] req1_vec_i,
    output logic [1:0]       req_ready_o,
    output logic             resp_valid_o,
    output logic             resp_id_o,
    output logic [VEC_W-1:0] resp_data_o,
    output logic             resp_err_o,
    input  logic             resp_ready_i,
    output logic [VEC_W-1:0] eng_vec_o,
    output logic             eng_start_o,
    input  logic             eng_done_i,
    input  logic [VEC_W-1:0] eng_mix_i
`ifdef MIX_SCHED_CG_EN
    ,
    output logic             eng_cg_en_o
`endif
);

    // Last BUSY cycle index before the job is aborted.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic             r_last;
    logic [7:0]       r_cnt;
    matrix_t          r_vec;
    logic             r_start;
    logic             r_cg_en;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [VEC_W-1:0] r_resp_data;
    logic             r_resp_err;
    logic [1:0]       w_grant;
    logic [1:0]       w_accept;
    logic             w_timeout;

    rr_arb2 u_arb (
        .i_req   (req_valid_i),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // Arbiter result only counts as an accept while idle.
    always_comb begin
        w_accept  = 2'b00;
        w_timeout = 1'b0;
        if (r_state == ST_IDLE) begin
            w_accept = w_grant;
        end else begin
            w_accept = 2'b00;
        end
        if (r_cnt == TO_LAST) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
    end

    // Next-state logic; done wins over timeout because both lead to RESP and the capture favours done.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    w_next_state = ST_LAUNCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                w_next_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (eng_done_i || w_timeout) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and registered outputs; reset holds the engine in reset via start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b1;
            r_cnt        <= 8'd0;
            r_vec        <= '0;
            r_start      <= 1'b1;
            r_cg_en      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_start      <= (w_next_state == ST_LAUNCH);
            r_cg_en      <= (w_next_state == ST_LAUNCH) || (w_next_state == ST_BUSY);
            r_resp_valid <= (w_next_state == ST_RESP);

            if (r_state == ST_LAUNCH) begin
                r_cnt <= 8'd0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_accept != 2'b00) begin
                r_vec  <= w_accept[1] ? req1_vec_i : req0_vec_i;
                r_last <= w_accept[1];
            end

            // r_last still names the owner of the in-flight job, so it doubles as the response id.
            if ((r_state == ST_BUSY) && eng_done_i) begin
                r_resp_data <= eng_mix_i;
                r_resp_err  <= 1'b0;
                r_resp_id   <= r_last;
            end else if ((r_state == ST_BUSY) && w_timeout) begin
                r_resp_data <= '0;
                r_resp_err  <= 1'b1;
                r_resp_id   <= r_last;
            end else if ((r_state == ST_RESP) && resp_ready_i) begin
                r_resp_data <= '0;
                r_resp_err  <= 1'b0;
                r_resp_id   <= 1'b0;
            end
        end
    end

    assign req_ready_o  = w_accept & {2{~rst_i}};
    assign resp_valid_o = r_resp_valid;
    assign resp_id_o    = r_resp_id;
    assign resp_data_o  = r_resp_data;
    assign resp_err_o   = r_resp_err;
    assign eng_vec_o    = r_vec;
    assign eng_start_o  = r_start;
`ifdef MIX_SCHED_CG_EN
    assign eng_cg_en_o  = r_cg_en;
`else
    // Without the gating port the enable register has no load and is trimmed away.
    logic w_cg_unused;
    assign w_cg_unused = r_cg_en;
`endif

endmodule

// File: tb/tb_mix_sched.sv
`timescale 1ns/1ps
module tb_mix_sched;
    import mix_pkg::*;

    localparam int TB_TO = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   req_valid_i;
    logic [127:0] req0_vec_i, req1_vec_i;
    logic [1:0]   req_ready_o;
    logic         resp_valid_o, resp_id_o, resp_err_o, resp_ready_i;
    logic [127:0] resp_data_o, eng_vec_o, eng_mix_i;
    logic         eng_start_o;
    logic         eng_done_i = 1'b0;
`ifdef MIX_SCHED_CG_EN
    logic         eng_cg_en_o;
`endif

    always #5 clk_i = ~clk_i;

    mix_sched #(.TIMEOUT(TB_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req0_vec_i(req0_vec_i), .req1_vec_i(req1_vec_i),
        .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o), .resp_ready_i(resp_ready_i),
        .eng_vec_o(eng_vec_o), .eng_start_o(eng_start_o),
        .eng_done_i(eng_done_i), .eng_mix_i(eng_mix_i)
`ifdef MIX_SCHED_CG_EN
        , .eng_cg_en_o(eng_cg_en_o)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Golden engine: matrix square mod 256 plus a per-position offset (i*DIM+j+1).
    function automatic logic [127:0] golden(input logic [127:0] v);
        matrix_t m, r;
        int s;
        m = v;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) s += int'(m[i][k]) * int'(m[k][j]);
                r[i][j] = 8'(s + i * DIM + j + 1);
            end
        end
        return r;
    endfunction

    // Engine model: restarts while start is high, raises done eng_lat cycles into the run, holds it.
    int           eng_lat = 0;
    int           ecnt = 0, elat = 0;
    bit           erun = 0;
    logic [127:0] evec = '0;
    always @(posedge clk_i) begin
        #1;
        if (eng_start_o === 1'b1) begin
            eng_done_i = 1'b0; ecnt = 0; erun = 1; evec = eng_vec_o; elat = eng_lat;
        end else if (erun) begin
            if (ecnt == elat) begin
                eng_done_i = 1'b1; eng_mix_i = golden(evec); erun = 0;
            end else begin
                ecnt++;
            end
        end
    end

    // Transaction-level reference: a job accepted in cycle A answers in cycle A+3+lat,
    // or A+2+TIMEOUT with error when the engine is slower than TIMEOUT-1.
    function automatic bit pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    int           cyc = 0;
    bit           m_ok = 0, m_job = 0, m_last = 1, m_rst = 0, m_id = 0, m_err = 0;
    int           m_acc = 0, m_resp = 0;
    logic [127:0] m_vec = '0, m_data = '0;

    always @(negedge clk_i) begin
        logic [1:0] e_rdy;
        bit         e_rv, g;
        cyc++;
        if (m_ok) begin
            e_rdy = 2'b00;
            if (!m_job && !rst_i && req_valid_i != 2'b00)
                e_rdy = pick(req_valid_i, m_last) ? 2'b10 : 2'b01;
            e_rv = m_job && (cyc >= m_resp);
            chk("req_ready", 128'(req_ready_o), 128'(e_rdy));
            chk("eng_start", 128'(eng_start_o), 128'(m_rst || (m_job && cyc == m_acc + 1)));
            chk("eng_vec", eng_vec_o, m_vec);
            chk("resp_valid", 128'(resp_valid_o), 128'(e_rv));
            chk("resp_data", resp_data_o, e_rv ? m_data : 128'h0);
            chk("resp_id", 128'(resp_id_o), 128'(e_rv & m_id));
            chk("resp_err", 128'(resp_err_o), 128'(e_rv & m_err));
`ifdef MIX_SCHED_CG_EN
            chk("eng_cg_en", 128'(eng_cg_en_o), 128'(m_job && cyc >= m_acc + 1 && cyc < m_resp));
`endif
        end
        if (rst_i) begin
            m_ok = 1; m_job = 0; m_last = 1; m_rst = 1; m_vec = '0;
        end else if (m_ok) begin
            m_rst = 0;
            if (m_job && cyc >= m_resp && resp_ready_i) begin
                m_job = 0;
            end else if (!m_job && req_valid_i != 2'b00) begin
                g      = pick(req_valid_i, m_last);
                m_job  = 1; m_acc = cyc; m_id = g; m_last = g;
                m_vec  = g ? req1_vec_i : req0_vec_i;
                if (eng_lat <= TB_TO - 1) begin
                    m_resp = cyc + 3 + eng_lat; m_err = 0; m_data = golden(m_vec);
                end else begin
                    m_resp = cyc + 2 + TB_TO; m_err = 1; m_data = '0;
                end
            end
        end
    end

    int n_start = 0, n_rdy = 0;
    always @(negedge clk_i) begin
        if (eng_start_o === 1'b1) n_start++;
        if (req_ready_o != 2'b00) n_rdy++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Raise valid for one requester, wait for its accept, then drop valid.
    task automatic issue(input int id, input logic [127:0] v);
        bit got;
        got = 0;
        if (id == 0) req0_vec_i = v; else req1_vec_i = v;
        req_valid_i[id] = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk_i);
            if (req_ready_o[id]) got = 1;
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL grant_wait: requester %0d never accepted", id);
        end
        step(1);
        req_valid_i[id] = 1'b0;
    endtask

    task automatic wait_resp(output int lat_c, output logic [127:0] d, output logic e);
        bit got;
        got = 0; lat_c = 0; d = '0; e = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk_i);
            lat_c++;
            if (resp_valid_o) begin got = 1; d = resp_data_o; e = resp_err_o; end
        end
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL resp_wait: no resp_valid_o within bound");
        end
    endtask

    initial begin
        int           lat_c, s0, r0;
        logic [127:0] d, held;
        logic         e;
        bit           ord [4];
        bit           exp_ord [4];
        bit           got;
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_i = 1'b1; req_valid_i = 2'b00; req0_vec_i = '0; req1_vec_i = '0;
        resp_ready_i = 1'b1; eng_mix_i = '0;
        step(3);
        rst_i = 1'b0;
        step(2);

        // Single request, zero vector, engine answers in the first BUSY cycle.
        eng_lat = 0; s0 = n_start; r0 = n_rdy;
        issue(0, 128'h0);
        wait_resp(lat_c, d, e);
        chk("lat_min", 128'(lat_c), 128'd3);
        chk("data_vec0", d, 128'h100f0e0d0c0b0a090807060504030201);
        step(3);
        chk("start_pulses", 128'(n_start - s0), 128'd1);
        chk("ready_pulses", 128'(n_rdy - r0), 128'd1);

        // Reset while BUSY: job dropped, engine held in reset, outputs cleared.
        eng_lat = 5;
        issue(0, 128'h0303);
        step(1);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_start", 128'(eng_start_o), 128'd1);
        chk("rst_valid", 128'(resp_valid_o), 128'd0);
        chk("rst_vec", eng_vec_o, 128'h0);
        step(12);

        // Both requesters valid continuously: strict alternation from requester 0.
        eng_lat = 2;
        req0_vec_i = 128'h0102; req1_vec_i = 128'h0201_0000_0000; req_valid_i = 2'b11;
        for (int j = 0; j < 4; j++) begin
            got = 0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk_i);
                if (req_ready_o != 2'b00) begin got = 1; ord[j] = req_ready_o[1]; end
            end
            step(1);
            if (ord[j]) req1_vec_i = {96'h0, 32'(j * 32'h0101_0107)};
            else        req0_vec_i = {32'(j * 32'h0305_0709), 96'h5};
            chk("grant_order", 128'(ord[j]), 128'(exp_ord[j]));
        end
        req_valid_i = 2'b00;
        wait_resp(lat_c, d, e);
        step(3);

        // Consumer stalls 20 cycles: result held, no new grant despite pending request.
        eng_lat = 1; resp_ready_i = 1'b0;
        req1_vec_i = 128'h0a0b0c0d;
        req_valid_i[1] = 1'b1;
        issue(0, 128'hff00_00ff);
        req_valid_i[1] = 1'b1;
        wait_resp(lat_c, held, e);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            chk("stall_valid", 128'(resp_valid_o), 128'd1);
            chk("stall_data", resp_data_o, held);
        end
        step(1);
        resp_ready_i = 1'b1;
        step(2);
        req_valid_i = 2'b00;
        wait_resp(lat_c, d, e);
        step(3);

        // Engine never finishes: abort after TIMEOUT BUSY cycles.
        eng_lat = 1000;
        issue(0, 128'h0707);
        wait_resp(lat_c, d, e);
        chk("to_lat", 128'(lat_c), 128'(2 + TB_TO));
        chk("to_err", 128'(e), 128'd1);
        chk("to_data", d, 128'h0);
        step(2);

        // Done on the timeout cycle itself wins.
        eng_lat = TB_TO - 1;
        issue(1, 128'h2);
        wait_resp(lat_c, d, e);
        chk("edge_lat", 128'(lat_c), 128'(2 + TB_TO));
        chk("edge_err", 128'(e), 128'd0);
        chk("edge_data", d, 128'h100f0e0d0c0b0a090807060504030205);
        step(2);

        // Requester 1 withdraws before the engine is free: it must not be granted.
        eng_lat = 3; r0 = n_rdy;
        issue(0, 128'h11);
        req_valid_i[1] = 1'b1;
        step(2);
        req_valid_i[1] = 1'b0;
        wait_resp(lat_c, d, e);
        step(4);
        chk("withdraw_grants", 128'(n_rdy - r0), 128'd1);

        // Long idle gap, then one more job.
        step(50);
        eng_lat = 2;
        issue(1, 128'h1234);
        wait_resp(lat_c, d, e);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
